// File: rtl/nmr_pkg.sv
// Shared types and helpers for the N-modular-redundancy comparator.
package nmr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_MAJ    = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nmr_majority.sv
// Combinational majority voter: lowest channel agreeing with a strict majority wins.
module nmr_majority
  import nmr_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_CH   = 3
) (
  input  logic [N_CH*DATA_W-1:0]          channels,
  output logic                            winner_valid,
  output logic [clog2_min1(N_CH)-1:0]     winner_idx,
  output logic [N_CH-1:0]                 fault_mask
);

  localparam int unsigned IDX_W = clog2_min1(N_CH);
  localparam int unsigned AGR_W = $clog2(N_CH + 1);

  logic [DATA_W-1:0] ch    [N_CH];
  logic [AGR_W-1:0]  agree [N_CH];

  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      ch[i] = channels[i*DATA_W +: DATA_W];
    end
  end

  // Number of channels equal to each channel, itself included.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      agree[i] = '0;
      for (int j = 0; j < int'(N_CH); j++) begin
        if (ch[i] == ch[j]) agree[i] = agree[i] + AGR_W'(1);
      end
    end
  end

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    winner_valid = 1'b0;
    winner_idx   = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (agree[i] > AGR_W'(N_CH / 2)) begin
        winner_valid = 1'b1;
        winner_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    fault_mask = '1;
    if (winner_valid) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        fault_mask[i] = (ch[i] != ch[winner_idx]);
      end
    end
  end

endmodule

// File: rtl/nmr_compare_v4.sv
// N-channel redundant result comparator with strict or majority compare,
// collection timeout, saturating mismatch counter and report interrupt.
module nmr_compare_v4
  import nmr_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_CH    = 3,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [N_CH-1:0]        data_set,
  input  logic                   ack,
  input  logic                   mode,
  output logic                   is_match,
  output logic [DATA_W-1:0]      voted_out,
  output logic [N_CH-1:0]        fault_mask,
  output logic                   done,
  output logic                   timeout,
  output logic [CNT_W-1:0]       mismatch_count,
  output logic                   interrupt_prompt
);

  localparam int unsigned IDX_W = clog2_min1(N_CH);
  localparam int unsigned TMR_W = clog2_min1(TIMEOUT);

  state_t                 state, state_next;
  logic [N_CH-1:0]        data_set_q;
  logic [N_CH-1:0]        rise;
  logic [N_CH-1:0]        got;
  logic [N_CH*DATA_W-1:0] cap;
  logic [TMR_W-1:0]       timer;
  logic                   enter_report;

  logic                   win_valid;
  logic [IDX_W-1:0]       win_idx;
  logic [N_CH-1:0]        maj_mask;

  logic                   res_match;
  logic [DATA_W-1:0]      res_voted;
  logic [N_CH-1:0]        res_mask;

  assign rise = data_set & ~data_set_q;

  nmr_majority #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH)
  ) u_majority (
    .channels     (cap),
    .winner_valid (win_valid),
    .winner_idx   (win_idx),
    .fault_mask   (maj_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Complete collection wins over an expiring timer in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|rise) state_next = COLLECT;
      COLLECT: begin
        if (&got)                               state_next = COMPARE;
        else if (timer == TMR_W'(TIMEOUT - 1))  state_next = REPORT;
      end
      COMPARE: state_next = REPORT;
      REPORT:  if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_report = (state_next == REPORT) && (state != REPORT);

  // Result to latch on REPORT entry; the timeout path keeps the defaults.
  always_comb begin
    res_match = 1'b0;
    res_voted = '0;
    res_mask  = ~got;
    if (state == COMPARE) begin
      case (mode)
        MODE_STRICT: begin
          for (int i = 0; i < int'(N_CH); i++) begin
            res_mask[i] = (cap[i*DATA_W +: DATA_W] != cap[0 +: DATA_W]);
          end
          res_match = ~|res_mask;
          res_voted = cap[0 +: DATA_W];
        end
        MODE_MAJ: begin
          res_match = win_valid;
          res_voted = win_valid ? cap[int'(win_idx)*DATA_W +: DATA_W] : '0;
          res_mask  = maj_mask;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_set_q       <= '0;
      got              <= '0;
      cap              <= '0;
      timer            <= '0;
      is_match         <= 1'b0;
      voted_out        <= '0;
      fault_mask       <= '0;
      done             <= 1'b0;
      timeout          <= 1'b0;
      mismatch_count   <= '0;
      interrupt_prompt <= 1'b0;
    end else begin
      data_set_q       <= data_set;
      interrupt_prompt <= enter_report;

      if (state == COLLECT) timer <= timer + TMR_W'(1);
      else                  timer <= '0;

      // Captures only while collecting; a repeated rise overwrites.
      if (state == IDLE || state == COLLECT) begin
        got <= got | rise;
        for (int i = 0; i < int'(N_CH); i++) begin
          if (rise[i]) cap[i*DATA_W +: DATA_W] <= data_in[i*DATA_W +: DATA_W];
        end
      end

      if (enter_report) begin
        is_match   <= res_match;
        voted_out  <= res_voted;
        fault_mask <= res_mask;
        timeout    <= (state == COLLECT);
        done       <= 1'b1;
        if (!res_match && mismatch_count != {CNT_W{1'b1}}) begin
          mismatch_count <= mismatch_count + CNT_W'(1);
        end
      end

      if (state == REPORT && ack) begin
        done     <= 1'b0;
        timeout  <= 1'b0;
        is_match <= 1'b0;
        got      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nmr_compare_v4.sv
// Self-checking bench for nmr_compare_v4 (N_CH=3, TIMEOUT=16, CNT_W=2).
module tb_nmr_compare_v4;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 3;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC*DW-1:0] data_in;
  logic [NC-1:0]    data_set;
  logic             ack;
  logic             mode;
  logic             is_match;
  logic [DW-1:0]    voted_out;
  logic [NC-1:0]    fault_mask;
  logic             done;
  logic             timeout;
  logic [CW-1:0]    mismatch_count;
  logic             interrupt_prompt;

  always #5 clk = ~clk;

  nmr_compare_v4 #(
    .DATA_W  (DW),
    .N_CH    (NC),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_in          (data_in),
    .data_set         (data_set),
    .ack              (ack),
    .mode             (mode),
    .is_match         (is_match),
    .voted_out        (voted_out),
    .fault_mask       (fault_mask),
    .done             (done),
    .timeout          (timeout),
    .mismatch_count   (mismatch_count),
    .interrupt_prompt (interrupt_prompt)
  );

  typedef struct {
    logic          md;
    logic [DW-1:0] d0, d1, d2;
    logic          m;
    logic [DW-1:0] v;
    logic [NC-1:0] k;
  } vec_t;

  typedef struct {
    logic          m;
    logic [DW-1:0] v;
    logic [NC-1:0] k;
    logic          t;
    logic [CW-1:0] c;
  } exp_t;

  exp_t          sbq[$];
  vec_t          vt[8];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] cnt_model = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int ch, input logic [DW-1:0] val);
    @(negedge clk);
    data_in[ch*DW +: DW] = val;
    data_set[ch] = 1'b1;
    @(negedge clk);
    data_set[ch] = 1'b0;
  endtask

  task automatic push_exp(input logic m, input logic [DW-1:0] v, input logic [NC-1:0] k,
                          input logic t);
    exp_t e;
    if (!m && cnt_model != {CW{1'b1}}) cnt_model = cnt_model + CW'(1);
    e.m = m; e.v = v; e.k = k; e.t = t; e.c = cnt_model;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (!done && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Checks result fields on the first done cycle, then the pulse width and ack release.
  task automatic check_report(input string tag, input int cyc, input int exp_cyc, input logic do_ack);
    exp_t e;
    chk({tag, "_latency"}, DW'(cyc), DW'(exp_cyc));
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_done"},     {31'd0, done},      32'd1);
    chk({tag, "_irq"},      {31'd0, interrupt_prompt}, 32'd1);
    chk({tag, "_match"},    {31'd0, is_match},  {31'd0, e.m});
    chk({tag, "_voted"},    voted_out,          e.v);
    chk({tag, "_mask"},     DW'(fault_mask),    DW'(e.k));
    chk({tag, "_timeout"},  {31'd0, timeout},   {31'd0, e.t});
    chk({tag, "_count"},    DW'(mismatch_count), DW'(e.c));
    @(negedge clk);
    chk({tag, "_irq_off"},  {31'd0, interrupt_prompt}, 32'd0);
    chk({tag, "_done_hold"}, {31'd0, done},     32'd1);
    if (do_ack) begin
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk({tag, "_ack_done"},  {31'd0, done},    32'd0);
      chk({tag, "_ack_tmo"},   {31'd0, timeout}, 32'd0);
      chk({tag, "_ack_match"}, {31'd0, is_match}, 32'd0);
      chk({tag, "_ack_voted"}, voted_out,        e.v);
      chk({tag, "_ack_mask"},  DW'(fault_mask),  DW'(e.k));
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int cyc;
    mode = v.md;
    load(0, v.d0);
    load(1, v.d1);
    load(2, v.d2);
    push_exp(v.m, v.v, v.k, 1'b0);
    wait_done(40, cyc);
    check_report(tag, cyc, 2, 1'b1);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done || timeout || interrupt_prompt) seen++;
    end
    chk(tag, DW'(seen), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_match"}, {31'd0, is_match},         32'd0);
    chk({tag, "_voted"}, voted_out,                 32'd0);
    chk({tag, "_mask"},  DW'(fault_mask),           32'd0);
    chk({tag, "_done"},  {31'd0, done},             32'd0);
    chk({tag, "_tmo"},   {31'd0, timeout},          32'd0);
    chk({tag, "_count"}, DW'(mismatch_count),       32'd0);
    chk({tag, "_irq"},   {31'd0, interrupt_prompt}, 32'd0);
  endtask

  initial begin
    int cyc;

    vt[0] = '{1'b0, 32'd255, 32'd255, 32'd255, 1'b1, 32'd255, 3'b000};
    vt[1] = '{1'b1, 32'd255, 32'd111, 32'd255, 1'b1, 32'd255, 3'b010};
    vt[2] = '{1'b0, 32'd255, 32'd111, 32'd255, 1'b0, 32'd255, 3'b010};
    vt[3] = '{1'b1, 32'd1,   32'd2,   32'd3,   1'b0, 32'd0,   3'b111};
    vt[4] = '{1'b1, 32'd7,   32'd7,   32'd9,   1'b1, 32'd7,   3'b100};
    vt[5] = '{1'b1, 32'd5,   32'd9,   32'd9,   1'b1, 32'd9,   3'b001};
    vt[6] = '{1'b0, 32'd0,   32'd0,   32'd1,   1'b0, 32'd0,   3'b100};
    vt[7] = '{1'b0, 32'd4,   32'd5,   32'd6,   1'b0, 32'd4,   3'b110};

    reset = 1'b1; data_in = '0; data_set = '0; ack = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Four mismatching vectors drive the 2-bit counter into saturation.
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Reset after results exist clears everything, including the counter.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    cnt_model = '0;
    @(negedge clk);
    check_zero("reset2");

    // Timeout with ch1 missing: 16 COLLECT cycles counted from the first rise.
    mode = 1'b0;
    load(0, 32'd42);
    load(2, 32'd42);
    push_exp(1'b0, 32'd0, 3'b010, 1'b1);
    wait_done(40, cyc);
    check_report("timeout", cyc, int'(TO) - 2, 1'b1);
    quiet("timeout_idle", 5);

    // ch1 re-rise overwrites; a rise during REPORT must not start a collection.
    mode = 1'b0;
    load(0, 32'd30);
    load(1, 32'd20);
    load(1, 32'd30);
    load(2, 32'd30);
    push_exp(1'b1, 32'd30, 3'b000, 1'b0);
    wait_done(40, cyc);
    data_in[0 +: DW] = 32'd99;
    data_set[0] = 1'b1;
    check_report("rerise", cyc, 2, 1'b1);
    quiet("report_rise_ignored", 20);
    data_set[0] = 1'b0;
    run_vec("after_ignore", '{1'b0, 32'd77, 32'd77, 32'd77, 1'b1, 32'd77, 3'b000});

    // Reset mid-collection aborts with no report.
    load(0, 32'd5);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    cnt_model = '0;
    @(negedge clk);
    check_zero("reset_collect");
    quiet("abort_quiet", 20);
    run_vec("post_abort", '{1'b1, 32'd1, 32'd2, 32'd3, 1'b0, 32'd0, 3'b111});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

endmodule
